// File: rtl/test_supervisor.sv
// Test supervisor: sequences harness reset, counts cycles, gathers per-channel results,
// enforces a timeout, gates the waveform-dump window and latches a PASS/FAIL verdict.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RST_SEQ | dut_reset held; channel inputs ignored until count hits RESET_CYCLES
// RUN     | collecting success/failure, checking timeout
// PASS    | terminal, passed=1; counter frozen
// FAIL    | terminal, fail_code/fail_ch hold the cause; counter frozen
module test_supervisor #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 64,
  parameter int RESET_CYCLES = 16,
  parameter bit MODE_ALL     = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CNT_W-1:0]          max_cycles,
  input  logic [CNT_W-1:0]          dump_start,
  input  logic [CNT_W-1:0]          dump_stop,
  input  logic [NUM_CH-1:0]         ch_success,
  input  logic [NUM_CH-1:0]         ch_failure,
  output logic                      dut_reset,
  output logic [CNT_W-1:0]          cycle_count,
  output logic                      dump_en,
  output logic                      done,
  output logic                      passed,
  output logic [1:0]                fail_code,
  output logic [$clog2(NUM_CH)-1:0] fail_ch,
  output logic [NUM_CH-1:0]         success_mask
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(RESET_CYCLES);

  typedef enum logic [1:0] {RST_SEQ, RUN, PASS, FAIL} state_t;

  state_t              state, state_nxt;
  logic                dut_reset_nxt, dump_en_nxt, done_nxt, passed_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic [CNT_W:0]      count_inc;
  logic [1:0]          fail_code_nxt;
  logic [CH_W-1:0]     fail_ch_nxt, low_ch;
  logic [NUM_CH-1:0]   mask_nxt, mask_seen;
  logic                terminal, pass_hit, timeout_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RST_SEQ;
      dut_reset    <= 1'b1;
      cycle_count  <= '0;
      dump_en      <= 1'b0;
      done         <= 1'b0;
      passed       <= 1'b0;
      fail_code    <= 2'd0;
      fail_ch      <= '0;
      success_mask <= '0;
    end else begin
      state        <= state_nxt;
      dut_reset    <= dut_reset_nxt;
      cycle_count  <= count_nxt;
      dump_en      <= dump_en_nxt;
      done         <= done_nxt;
      passed       <= passed_nxt;
      fail_code    <= fail_code_nxt;
      fail_ch      <= fail_ch_nxt;
      success_mask <= mask_nxt;
    end
  end

  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_failure[i]) low_ch = CH_W'(i);
    end
  end

  // One extra bit so the timeout compare stays exact at the top of the count range.
  assign count_inc   = {1'b0, cycle_count} + 1'b1;
  assign terminal    = (state == PASS) || (state == FAIL);
  assign mask_seen   = success_mask | ch_success;
  assign pass_hit    = MODE_ALL ? (&mask_seen) : (|mask_seen);
  assign timeout_hit = (max_cycles != '0) && (count_inc >= {1'b0, max_cycles});

  always_comb begin
    state_nxt     = state;
    dut_reset_nxt = dut_reset;
    done_nxt      = done;
    passed_nxt    = passed;
    fail_code_nxt = fail_code;
    fail_ch_nxt   = fail_ch;
    mask_nxt      = success_mask;

    if (terminal || (&cycle_count)) count_nxt = cycle_count;
    else                            count_nxt = count_inc[CNT_W-1:0];

    case (state)
      RST_SEQ: begin
        if (count_nxt == RST_LEN) begin
          state_nxt     = RUN;
          dut_reset_nxt = 1'b0;
        end
      end
      RUN: begin
        mask_nxt = mask_seen;
        if (|ch_failure) begin
          state_nxt     = FAIL;
          done_nxt      = 1'b1;
          fail_code_nxt = 2'd1;
          fail_ch_nxt   = low_ch;
        end else if (timeout_hit) begin
          state_nxt     = FAIL;
          done_nxt      = 1'b1;
          fail_code_nxt = 2'd2;
        end else if (pass_hit) begin
          state_nxt  = PASS;
          done_nxt   = 1'b1;
          passed_nxt = 1'b1;
        end
      end
      default: ;
    endcase

    // done is the registered flag, so the window closes one edge after the verdict.
    dump_en_nxt = !done && (count_nxt >= dump_start) &&
                  ((dump_stop == '0) || (count_nxt < dump_stop));
  end

endmodule

// File: tb/tb_test_supervisor.sv
// Directed bench for test_supervisor: table of verdict scenarios plus hand-written
// sequences for the reset sequence, dump window and mid-run reset.
module tb_test_supervisor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic [CNT_W-1:0]  max_cycles, dump_start, dump_stop;
  logic [NUM_CH-1:0] ch_success, ch_failure;
  logic              dut_reset, dump_en, done, passed;
  logic [CNT_W-1:0]  cycle_count;
  logic [1:0]        fail_code;
  logic [1:0]        fail_ch;
  logic [NUM_CH-1:0] success_mask;

  int n_pass = 0;
  int n_total = 0;

  test_supervisor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_CYCLES(16), .MODE_ALL(1'b1)) dut (
    .clock(clock), .reset(reset), .max_cycles(max_cycles), .dump_start(dump_start),
    .dump_stop(dump_stop), .ch_success(ch_success), .ch_failure(ch_failure),
    .dut_reset(dut_reset), .cycle_count(cycle_count), .dump_en(dump_en), .done(done),
    .passed(passed), .fail_code(fail_code), .fail_ch(fail_ch), .success_mask(success_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] max_c;
    int          fail_at;
    logic [3:0]  fail_vec;
    logic [3:0]  succ_en;
    logic [63:0] exp_cnt;
    logic        exp_pass;
    logic [1:0]  exp_code;
    logic [1:0]  exp_ch;
    logic [3:0]  exp_mask;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ch_success = '0;
    ch_failure = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Success pulse schedule: channel bit presented on the edge that makes cycle_count == k.
  function automatic logic [3:0] sched(input int k);
    case (k)
      20: return 4'b0001;
      25: return 4'b0100;
      30: return 4'b0010;
      40: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    int k;
    reset = 1'b1;
    max_cycles = '0; dump_start = '0; dump_stop = '0;
    ch_success = '0; ch_failure = '0;

    //                max   fail_at vec    succ   cnt    pass code ch  mask
    vecs[0] = '{64'd0,   0,  4'h0, 4'hF, 64'd40,  1'b1, 2'd0, 2'd0, 4'hF};
    vecs[1] = '{64'd100, 0,  4'h0, 4'h0, 64'd100, 1'b0, 2'd2, 2'd0, 4'h0};
    vecs[2] = '{64'd0,   40, 4'h6, 4'hF, 64'd40,  1'b0, 2'd1, 2'd1, 4'hF};
    vecs[3] = '{64'd0,   5,  4'hF, 4'hF, 64'd40,  1'b1, 2'd0, 2'd0, 4'hF};
    vecs[4] = '{64'd35,  0,  4'h0, 4'h7, 64'd35,  1'b0, 2'd2, 2'd0, 4'h7};
    vecs[5] = '{64'd40,  0,  4'h0, 4'hF, 64'd40,  1'b0, 2'd2, 2'd0, 4'hF};
    vecs[6] = '{64'd0,   33, 4'h8, 4'hF, 64'd33,  1'b0, 2'd1, 2'd3, 4'h7};
    vecs[7] = '{64'd17,  0,  4'h0, 4'h0, 64'd17,  1'b0, 2'd2, 2'd0, 4'h0};

    // Reset values and the 16-edge reset sequence, dump window open from count 1.
    #2;
    chk("rst_dut_reset", 64'(dut_reset), 64'd1);
    chk("rst_count", cycle_count, 64'd0);
    chk("rst_dump_en", 64'(dump_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mask", 64'(success_mask), 64'd0);
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      ch_failure = (i == 5) ? 4'hF : 4'h0;
      step();
      chk("seq_dut_reset", 64'(dut_reset), (i < 16) ? 64'd1 : 64'd0);
      chk("seq_count", cycle_count, 64'(i));
      chk("seq_dump_en", 64'(dump_en), 64'd1);
      chk("seq_done", 64'(done), 64'd0);
    end

    // Verdict scenarios.
    for (int v = 0; v < NV; v++) begin
      max_cycles = vecs[v].max_c;
      dump_start = '0;
      dump_stop  = '0;
      do_reset();
      k = 0;
      while (!done && k < 300) begin
        k++;
        ch_success = sched(k) & vecs[v].succ_en;
        ch_failure = (k == vecs[v].fail_at) ? vecs[v].fail_vec : 4'h0;
        step();
      end
      ch_success = '0;
      ch_failure = '0;
      chk($sformatf("v%0d_done", v), 64'(done), 64'd1);
      chk($sformatf("v%0d_passed", v), 64'(passed), 64'(vecs[v].exp_pass));
      chk($sformatf("v%0d_code", v), 64'(fail_code), 64'(vecs[v].exp_code));
      if (vecs[v].exp_code == 2'd1)
        chk($sformatf("v%0d_ch", v), 64'(fail_ch), 64'(vecs[v].exp_ch));
      chk($sformatf("v%0d_mask", v), 64'(success_mask), 64'(vecs[v].exp_mask));
      chk($sformatf("v%0d_count", v), cycle_count, vecs[v].exp_cnt);
      chk($sformatf("v%0d_dump_at_done", v), 64'(dump_en), 64'd1);
      ch_success = 4'hF;
      repeat (3) step();
      ch_success = '0;
      chk($sformatf("v%0d_frozen", v), cycle_count, vecs[v].exp_cnt);
      chk($sformatf("v%0d_dump_off", v), 64'(dump_en), 64'd0);
      chk($sformatf("v%0d_done_sticky", v), 64'(done), 64'd1);
      chk($sformatf("v%0d_passed_sticky", v), 64'(passed), 64'(vecs[v].exp_pass));
      chk($sformatf("v%0d_dut_reset", v), 64'(dut_reset), 64'd0);
    end

    // Dump window: [20,30) and an empty window with stop <= start.
    max_cycles = '0;
    for (int s = 0; s < 2; s++) begin
      dump_start = (s == 0) ? 64'd20 : 64'd30;
      dump_stop  = (s == 0) ? 64'd30 : 64'd20;
      do_reset();
      for (int i = 1; i <= 35; i++) begin
        step();
        chk($sformatf("dump%0d_k%0d", s, i), 64'(dump_en),
            (s == 0 && i >= 20 && i < 30) ? 64'd1 : 64'd0);
      end
    end

    // Mid-run reset at count 60, then the whole sequence repeats.
    dump_start = '0;
    dump_stop  = '0;
    do_reset();
    repeat (60) step();
    chk("mid_count_before", cycle_count, 64'd60);
    reset = 1'b1;
    #1;
    chk("mid_async_dut_reset", 64'(dut_reset), 64'd1);
    chk("mid_async_count", cycle_count, 64'd0);
    chk("mid_async_dump_en", 64'(dump_en), 64'd0);
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("mid_seq_dut_reset", 64'(dut_reset), (i < 16) ? 64'd1 : 64'd0);
    end
    ch_success = 4'hF;
    step();
    ch_success = '0;
    chk("mid_done", 64'(done), 64'd1);
    chk("mid_passed", 64'(passed), 64'd1);
    chk("mid_count", cycle_count, 64'd17);
    chk("mid_mask", 64'(success_mask), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
